// File: rtl/chunked_seq_adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
//   Shared types and helpers for the chunked sequential adder.
//   - adder_state_t : FSM state encoding (IDLE -> CALC -> DONE).
//   - cnt_width()   : width of the chunk counter. It returns at least 1, so that
//                     a single-chunk configuration still has a legal counter.
// -----------------------------------------------------------------------------
package adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } adder_state_t;

    function automatic int cnt_width(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/chunked_seq_adder_chunk_full_adder.sv
// -----------------------------------------------------------------------------
// chunk_full_adder
//   Combinational W-bit ripple-carry full-adder slice. It is one full-adder
//   cell per bit, chained through the carry.
//   Ports:
//     a, b : W-bit addends
//     cin  : carry into bit 0
//     sum  : W-bit sum
//     cout : carry out of bit W-1
// -----------------------------------------------------------------------------
module chunk_full_adder #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] carry;

    assign carry[0] = cin;

    for (genvar gi = 0; gi < W; gi++) begin : g_bit
        assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
        assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end

    assign cout = carry[W];

endmodule

// File: rtl/chunked_seq_adder.sv
// -----------------------------------------------------------------------------
// chunked_seq_adder
//   Multi-cycle adder/subtractor. It processes a WIDTH-bit operand pair CHUNK
//   bits per cycle, starting with the LSB chunk. A single chunk_full_adder slice
//   is reused on every cycle, and the carry between cycles is held in a register.
//   Ports:
//     clk_i, rst_ni          : clock (rising edge), synchronous active-low reset
//     in_valid_i/in_ready_o  : operand handshake (ready only in IDLE)
//     a_i, b_i, cin_i, sub_i : operands; sub_i=1 computes A-B and ignores cin_i
//     out_valid_o/out_ready_i: result handshake (valid only in DONE)
//     sum_o, cout_o, ovf_o   : result, final carry (no-borrow when
//                              subtracting), signed overflow
//     busy_o                 : high in CALC or DONE
// -----------------------------------------------------------------------------
module chunked_seq_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic             sub_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o,
    output logic             busy_o
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = cnt_width(NCHUNK);

    if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_params
        $error("chunked_seq_adder: WIDTH must be a positive multiple of CHUNK");
    end

    adder_state_t     state_reg, state_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;     // already inverted for subtraction
    logic [WIDTH-1:0] sum_reg, sum_next;
    logic             carry_reg, carry_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             cout_reg, cout_next;
    logic             ovf_reg, ovf_next;

    // The operands are viewed as arrays of chunks so that the slice mux is a
    // plain indexed selection.
    logic [CHUNK-1:0] a_chunks [NCHUNK];
    logic [CHUNK-1:0] b_chunks [NCHUNK];

    for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
        assign a_chunks[gi] = a_reg[gi*CHUNK +: CHUNK];
        assign b_chunks[gi] = b_reg[gi*CHUNK +: CHUNK];
    end

    logic [CHUNK-1:0] a_slice, b_slice, slice_sum;
    logic             slice_cout;
    logic             last_chunk;

    always_comb begin
        a_slice = '0;
        b_slice = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (cnt_reg == CNT_W'(k)) begin
                a_slice = a_chunks[k];
                b_slice = b_chunks[k];
            end
        end
    end

    chunk_full_adder #(.W(CHUNK)) u_slice (
        .a    (a_slice),
        .b    (b_slice),
        .cin  (carry_reg),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    assign last_chunk = (cnt_reg == CNT_W'(NCHUNK - 1));

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        sum_next   = sum_reg;
        carry_next = carry_reg;
        cnt_next   = cnt_reg;
        cout_next  = cout_reg;
        ovf_next   = ovf_reg;

        unique case (state_reg)
            ST_IDLE: begin
                if (in_valid_i) begin
                    a_next     = a_i;
                    b_next     = sub_i ? ~b_i : b_i;
                    carry_next = sub_i ? 1'b1 : cin_i;
                    sum_next   = '0;
                    cnt_next   = '0;
                    cout_next  = 1'b0;
                    ovf_next   = 1'b0;
                    state_next = ST_CALC;
                end
            end
            ST_CALC: begin
                for (int k = 0; k < NCHUNK; k++) begin
                    if (cnt_reg == CNT_W'(k)) begin
                        sum_next[k*CHUNK +: CHUNK] = slice_sum;
                    end
                end
                carry_next = slice_cout;
                if (last_chunk) begin
                    cnt_next   = '0;
                    cout_next  = slice_cout;
                    // The last slice holds the result MSB, so overflow is
                    // taken from the fresh slice sum and not from sum_reg.
                    ovf_next   = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                                 (slice_sum[CHUNK-1] != a_reg[WIDTH-1]);
                    state_next = ST_DONE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready_i) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg <= ST_IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            sum_reg   <= sum_next;
            carry_reg <= carry_next;
            cnt_reg   <= cnt_next;
            cout_reg  <= cout_next;
            ovf_reg   <= ovf_next;
        end
    end

    assign in_ready_o  = (state_reg == ST_IDLE);
    assign out_valid_o = (state_reg == ST_DONE);
    assign busy_o      = (state_reg != ST_IDLE);
    assign sum_o       = sum_reg;
    assign cout_o      = cout_reg;
    assign ovf_o       = ovf_reg;

endmodule

// File: tb/tb_chunked_seq_adder.sv
module tb_chunked_seq_adder;

    localparam int WIDTH = 16;
    localparam int CHUNK = 4;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic             clk_i;
    logic             rst_ni;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             cin_i;
    logic             sub_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH-1:0] sum_o;
    logic             cout_o;
    logic             ovf_o;
    logic             busy_o;

    chunked_seq_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .cin_i       (cin_i),
        .sub_i       (sub_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .sum_o       (sum_o),
        .cout_o      (cout_o),
        .ovf_o       (ovf_o),
        .busy_o      (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        int          stall;
        logic [15:0] exp_sum;
        logic        exp_cout;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Runs one full transaction: it waits for ready, accepts the operands,
    // then scrambles the inputs. It waits for the result, optionally stalls,
    // and then consumes the result.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub, input int stall,
                          output logic [15:0] s, output logic co, output logic ov,
                          output int lat);
        int n;
        n = 0;
        while (!in_ready_o && n < 50) begin
            @(posedge clk_i); #1;
            n++;
        end
        check("in_ready_before_op", 32'(in_ready_o), 32'd1);
        a_i = a; b_i = b; cin_i = cin; sub_i = sub; in_valid_i = 1'b1;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        a_i = 16'hDEAD; b_i = 16'hBEEF; cin_i = ~cin; sub_i = ~sub;
        lat = 0;
        while (!out_valid_o && lat < 50) begin
            @(posedge clk_i); #1;
            lat++;
        end
        s = sum_o; co = cout_o; ov = ovf_o;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk_i); #1;
            check("hold_sum_stall", 32'(sum_o), 32'(s));
        end
        out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        out_ready_i = 1'b0;
        check("out_valid_drop", 32'(out_valid_o), 32'd0);
    endtask

    initial begin
        logic [15:0] s, hold;
        logic        co, ov;
        int          lat;
        logic [15:0] ra, rb, bp;
        logic        rcin, rsub, mc, movf;
        logic [16:0] t;

        vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 0, 16'h0100, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 2, 16'hFFFE, 1'b0, 1'b0};
        vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 16'h8000, 1'b0, 1'b1};
        vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{16'h1234, 16'h1111, 1'b0, 1'b0, 0, 16'h2345, 1'b0, 1'b0};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 3, 16'h0000, 1'b1, 1'b1};
        vecs[7] = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 0, 16'h0000, 1'b1, 1'b0};
        vecs[8] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 0, 16'hFFFF, 1'b0, 1'b0};
        vecs[9] = '{16'hABCD, 16'h1234, 1'b1, 1'b0, 2, 16'hBE02, 1'b0, 1'b0};

        rst_ni = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        a_i = '0; b_i = '0; cin_i = 1'b0; sub_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("reset_in_ready", 32'(in_ready_o), 32'd1);
        check("reset_out_valid", 32'(out_valid_o), 32'd0);
        check("reset_busy", 32'(busy_o), 32'd0);
        check("reset_sum", 32'(sum_o), 32'd0);
        check("reset_cout", 32'(cout_o), 32'd0);
        check("reset_ovf", 32'(ovf_o), 32'd0);
        rst_ni = 1'b1;

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, vecs[i].stall, s, co, ov, lat);
            check("vec_sum", 32'(s), 32'(vecs[i].exp_sum));
            check("vec_cout", 32'(co), 32'(vecs[i].exp_cout));
            check("vec_ovf", 32'(ov), 32'(vecs[i].exp_ovf));
            check("vec_latency", 32'(lat), 32'(NCHUNK));
            $display("vec %0d: a=%04h b=%04h cin=%0b sub=%0b -> sum=%04h cout=%0b ovf=%0b lat=%0d",
                     i, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, s, co, ov, lat);
        end

        // Backpressure in DONE with a competing in_valid_i
        a_i = 16'h0003; b_i = 16'h0004; cin_i = 1'b0; sub_i = 1'b0; in_valid_i = 1'b1;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        check("calc_in_ready", 32'(in_ready_o), 32'd0);
        check("calc_busy", 32'(busy_o), 32'd1);
        lat = 0;
        while (!out_valid_o && lat < 50) begin
            @(posedge clk_i); #1;
            lat++;
        end
        check("bp_latency", 32'(lat), 32'(NCHUNK));
        hold = sum_o;
        check("bp_sum", 32'(hold), 32'h0007);
        in_valid_i = 1'b1; a_i = 16'h1111; b_i = 16'h2222;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i); #1;
            check("bp_hold_sum", 32'(sum_o), 32'(hold));
            check("bp_in_ready", 32'(in_ready_o), 32'd0);
            check("bp_out_valid", 32'(out_valid_o), 32'd1);
        end
        in_valid_i = 1'b0; out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        out_ready_i = 1'b0;
        check("bp_release_valid", 32'(out_valid_o), 32'd0);
        check("bp_release_ready", 32'(in_ready_o), 32'd1);
        check("bp_release_busy", 32'(busy_o), 32'd0);
        $display("backpressure: a=0003 b=0004 -> sum=%04h held 5 cycles", hold);

        // Reset while slice 2 is being computed
        a_i = 16'hFFFF; b_i = 16'h0001; cin_i = 1'b0; sub_i = 1'b0; in_valid_i = 1'b1;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        rst_ni = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        check("midreset_in_ready", 32'(in_ready_o), 32'd1);
        check("midreset_out_valid", 32'(out_valid_o), 32'd0);
        check("midreset_sum", 32'(sum_o), 32'd0);
        check("midreset_busy", 32'(busy_o), 32'd0);
        run_op(16'h1234, 16'h1111, 1'b0, 1'b0, 0, s, co, ov, lat);
        check("post_reset_sum", 32'(s), 32'h2345);
        check("post_reset_latency", 32'(lat), 32'(NCHUNK));
        $display("mid-calc reset, then a=1234 b=1111 -> sum=%04h", s);

        // Random operations against a reference model
        for (int i = 0; i < 100; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            rcin = 1'($urandom); rsub = 1'($urandom);
            bp = rsub ? ~rb : rb;
            t = {1'b0, ra} + {1'b0, bp} + 17'(rsub ? 1'b1 : rcin);
            mc = t[16];
            movf = (ra[15] == bp[15]) && (t[15] != ra[15]);
            run_op(ra, rb, rcin, rsub, int'($urandom_range(0, 3)), s, co, ov, lat);
            check("rand_sum", 32'(s), 32'(t[15:0]));
            check("rand_cout", 32'(co), 32'(mc));
            check("rand_ovf", 32'(ov), 32'(movf));
            check("rand_latency", 32'(lat), 32'(NCHUNK));
            $display("rand %0d: a=%04h b=%04h cin=%0b sub=%0b -> sum=%04h cout=%0b ovf=%0b",
                     i, ra, rb, rcin, rsub, s, co, ov);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
